// File: rtl/seq_magnitude_comp_pkg.sv
// Shared definitions for the sequential magnitude comparator: FSM state
// encoding and the one-hot {agtb, aeqb, altb} result encoding.
package seq_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Result vector ordering is {agtb, aeqb, altb}.
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/seq_magnitude_comp_if.sv
// Start/done handshake and result bus of the sequential magnitude comparator.
interface seq_magnitude_comp_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             agtb;
    logic             aeqb;
    logic             altb;

    // Requester side: issues compares and consumes results.
    modport master (
        output start, signed_mode, a, b,
        input  busy, done, agtb, aeqb, altb
    );

    // Comparator side.
    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, agtb, aeqb, altb
    );

endinterface

// File: rtl/seq_magnitude_comp_cmp_digit.sv
// Combinational DIGIT-bit unsigned comparator applied to the current digit.
module cmp_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq
);

    // NOTE: continuous assigns give pure combinational logic; no path can leave an output unassigned, so no latch.
    assign gt = (a > b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_magnitude_comp.sv
// Multi-cycle magnitude comparator: walks the operands MSB-first, DIGIT bits
// per clock, and exits early on the first differing digit.
module seq_magnitude_comp
    import seq_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    seq_magnitude_comp_if.slave bus
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || (WIDTH % DIGIT != 0)) begin : g_bad_params
            $fatal(1, "seq_magnitude_comp: WIDTH must be a multiple of DIGIT, 1 <= DIGIT <= WIDTH");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       result;
    logic             busy_q;
    logic             done_q;
    logic             dig_gt;
    logic             dig_eq;

    // Offset-binary trick: flipping both sign bits maps two's complement
    // order onto unsigned order, so one unsigned digit compare serves both.
    function automatic logic [WIDTH-1:0] bias(input logic [WIDTH-1:0] v, input logic s);
        return v ^ (WIDTH'(s) << (WIDTH - 1));
    endfunction

    cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
        .a  (a_sh[WIDTH-1 -: DIGIT]),
        .b  (b_sh[WIDTH-1 -: DIGIT]),
        .gt (dig_gt),
        .eq (dig_eq)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            result <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh   <= bias(bus.a, bus.signed_mode);
                        b_sh   <= bias(bus.b, bus.signed_mode);
                        cnt    <= CNT_LAST;
                        busy_q <= 1'b1;
                        state  <= COMPARE;
                    end else begin
                        state  <= IDLE;
                    end
                end
                COMPARE: begin
                    if (!dig_eq) begin
                        result <= dig_gt ? GT : LT;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else if (cnt == '0) begin
                        result <= EQ;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        a_sh <= a_sh << DIGIT;
                        b_sh <= b_sh << DIGIT;
                        cnt  <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign {bus.agtb, bus.aeqb, bus.altb} = result;

endmodule

// File: tb/tb_seq_magnitude_comp.sv
// Directed bench for seq_magnitude_comp (WIDTH=8, DIGIT=2) plus an exhaustive
// WIDTH=4 sweep over DIGIT = 1, 2, 4 against a behavioural model.
module tb_seq_magnitude_comp;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    seq_magnitude_comp_if #(.WIDTH(8)) bus ();
    seq_magnitude_comp_if #(.WIDTH(4)) sif1 ();
    seq_magnitude_comp_if #(.WIDTH(4)) sif2 ();
    seq_magnitude_comp_if #(.WIDTH(4)) sif4 ();

    seq_magnitude_comp #(.WIDTH(8), .DIGIT(2)) dut    (.clk(clk), .rst_n(rst_n), .bus(bus));
    seq_magnitude_comp #(.WIDTH(4), .DIGIT(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(sif1));
    seq_magnitude_comp #(.WIDTH(4), .DIGIT(2)) dut_w2 (.clk(clk), .rst_n(rst_n), .bus(sif2));
    seq_magnitude_comp #(.WIDTH(4), .DIGIT(4)) dut_w4 (.clk(clk), .rst_n(rst_n), .bus(sif4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request on the main DUT; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = s;
        @(negedge clk);
        bus.start       = 1'b0;
    endtask

    // Count edges until done (bounded); busy_cnt counts busy samples seen before done.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.done && bus.busy) busy_cnt++;
        end while (!bus.done && lat < 20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0;
        sif1.start = 1'b0; sif1.a = '0; sif1.b = '0; sif1.signed_mode = 1'b0;
        sif2.start = 1'b0; sif2.a = '0; sif2.b = '0; sif2.signed_mode = 1'b0;
        sif4.start = 1'b0; sif4.a = '0; sif4.b = '0; sif4.signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.agtb, bus.aeqb, bus.altb} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {bus.busy, bus.done, bus.agtb, bus.aeqb, bus.altb});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_equal();
        int lat, bc;
        issue(8'hA5, 8'hA5, 1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL equal_busy_rise: got %b required 1", bus.busy);
        end
        wait_done(lat, bc);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL equal_latency: got %0d required 4", lat);
        end
        checks++;
        if (bc + 1 != 4) begin
            errors++;
            $display("FAIL equal_busy_cycles: got %0d required 4", bc + 1);
        end
        checks++;
        if ({bus.agtb, bus.aeqb, bus.altb, bus.busy} !== 4'b0100) begin
            errors++;
            $display("FAIL equal_result: got %b required 0100", {bus.agtb, bus.aeqb, bus.altb, bus.busy});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.done, bus.agtb, bus.aeqb, bus.altb} !== 4'b0010) begin
            errors++;
            $display("FAIL equal_pulse_hold: got %b required 0010", {bus.done, bus.agtb, bus.aeqb, bus.altb});
        end
    endtask

    task automatic test_msb();
        int lat, bc;
        issue(8'h80, 8'h7F, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat != 1 || {bus.agtb, bus.aeqb, bus.altb} !== 3'b100) begin
            errors++;
            $display("FAIL msb_unsigned: got lat %0d res %b required lat 1 res 100", lat, {bus.agtb, bus.aeqb, bus.altb});
        end
        issue(8'h80, 8'h7F, 1'b1);
        wait_done(lat, bc);
        checks++;
        if (lat != 1 || {bus.agtb, bus.aeqb, bus.altb} !== 3'b001) begin
            errors++;
            $display("FAIL msb_signed: got lat %0d res %b required lat 1 res 001", lat, {bus.agtb, bus.aeqb, bus.altb});
        end
    endtask

    task automatic test_ignore_busy();
        int lat, bc;
        issue(8'h12, 8'h13, 1'b0);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bc);
        checks++;
        if (lat + 1 != 4 || {bus.agtb, bus.aeqb, bus.altb} !== 3'b001) begin
            errors++;
            $display("FAIL busy_ignore: got lat %0d res %b required lat 4 res 001", lat + 1, {bus.agtb, bus.aeqb, bus.altb});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.agtb, bus.aeqb, bus.altb} !== 5'b00001) begin
            errors++;
            $display("FAIL busy_ignore_idle: got %b required 00001", {bus.busy, bus.done, bus.agtb, bus.aeqb, bus.altb});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va  [3] = '{8'hA5, 8'h30, 8'h3C};
        logic [7:0] vb  [3] = '{8'hA4, 8'hC0, 8'h3C};
        logic [2:0] exp [3] = '{3'b100, 3'b001, 3'b010};
        int         elat[3] = '{4, 1, 4};
        int         lat, bc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.start       = 1'b1;
            bus.a           = va[i];
            bus.b           = vb[i];
            bus.signed_mode = 1'b0;
            @(posedge clk);
            wait_done(lat, bc);
            checks++;
            if (lat != elat[i] || {bus.agtb, bus.aeqb, bus.altb} !== exp[i]) begin
                errors++;
                $display("FAIL back_to_back_%0d: got lat %0d res %b required lat %0d res %b",
                         i, lat, {bus.agtb, bus.aeqb, bus.altb}, elat[i], exp[i]);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++;
            $display("FAIL back_to_back_idle: got busy/done %b required 00", {bus.busy, bus.done});
        end
    endtask

    task automatic test_reset_abort();
        int lat, bc;
        int seen_done;
        issue(8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.agtb, bus.aeqb, bus.altb} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_outputs: got %b required 00000", {bus.busy, bus.done, bus.agtb, bus.aeqb, bus.altb});
        end
        seen_done = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses required 0", seen_done);
        end
        issue(8'h55, 8'hAA, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat != 1 || {bus.agtb, bus.aeqb, bus.altb} !== 3'b001) begin
            errors++;
            $display("FAIL abort_recover: got lat %0d res %b required lat 1 res 001", lat, {bus.agtb, bus.aeqb, bus.altb});
        end
    endtask

    // Behavioural reference for the WIDTH=4 sweep.
    function automatic logic [2:0] model_res(input logic [3:0] x, input logic [3:0] y, input logic s);
        int xi, yi;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        if (xi > yi) return 3'b100;
        if (xi < yi) return 3'b001;
        return 3'b010;
    endfunction

    function automatic int model_lat(input logic [3:0] x, input logic [3:0] y, input int d);
        logic [3:0] diff;
        diff = x ^ y;
        for (int i = 3; i >= 0; i--) begin
            if (diff[i]) return (3 - i) / d + 1;
        end
        return 4 / d;
    endfunction

    task automatic test_sweep();
        int         lat [3];
        logic [2:0] res [3];
        int         dig [3] = '{1, 2, 4};
        logic [2:0] er;
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    @(negedge clk);
                    sif1.start = 1'b1; sif1.a = 4'(x); sif1.b = 4'(y); sif1.signed_mode = 1'(s);
                    sif2.start = 1'b1; sif2.a = 4'(x); sif2.b = 4'(y); sif2.signed_mode = 1'(s);
                    sif4.start = 1'b1; sif4.a = 4'(x); sif4.b = 4'(y); sif4.signed_mode = 1'(s);
                    @(negedge clk);
                    sif1.start = 1'b0;
                    sif2.start = 1'b0;
                    sif4.start = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        lat[k] = 99;
                        res[k] = 3'bxxx;
                    end
                    for (int c = 1; c <= 6; c++) begin
                        @(posedge clk);
                        #1;
                        if (sif1.done && lat[0] == 99) begin lat[0] = c; res[0] = {sif1.agtb, sif1.aeqb, sif1.altb}; end
                        if (sif2.done && lat[1] == 99) begin lat[1] = c; res[1] = {sif2.agtb, sif2.aeqb, sif2.altb}; end
                        if (sif4.done && lat[2] == 99) begin lat[2] = c; res[2] = {sif4.agtb, sif4.aeqb, sif4.altb}; end
                    end
                    er = model_res(4'(x), 4'(y), 1'(s));
                    for (int k = 0; k < 3; k++) begin
                        checks++;
                        if (res[k] !== er) begin
                            errors++;
                            $display("FAIL sweep_res d%0d s%0d a%0h b%0h: got %b required %b",
                                     dig[k], s, x, y, res[k], er);
                        end
                        checks++;
                        if (lat[k] != model_lat(4'(x), 4'(y), dig[k])) begin
                            errors++;
                            $display("FAIL sweep_lat d%0d s%0d a%0h b%0h: got %0d required %0d",
                                     dig[k], s, x, y, lat[k], model_lat(4'(x), 4'(y), dig[k]));
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_equal();
        test_msb();
        test_ignore_busy();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
